nn_weight_loader: RTL and testbench

- Streams network weights into the inference datapath, replacing the hard-wired XOR constants.
- Accepts one frame of signed weight words over a valid/ready stream and stages them in shadow registers.
- Commits the whole set atomically to the active weights read by the network, so the network never sees a partially written set.
- Sits between the host bus adapter and the NN core, as the writer side of the weight interface the core reads.

---
 rtl/nn_pkg.sv | 38 +++
 rtl/nn_weight_bank.sv | 45 ++++
 rtl/nn_weight_loader.sv | 149 ++++++++++++++
 tb/tb_nn_weight_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the NN weight path: sizing helpers, loader states and XOR default weights.
// The loader's checksummed frame format is selected by NN_LOADER_CHECKSUM_EN.
package nn_pkg;

  localparam int BITS_PER_WORD_DEF = 8;

  typedef enum logic [1:0] {LOAD, DRAIN, COMMIT} loader_state_t;

  function automatic int nn_n1(input int input_size, input int hidden_size);
    return (input_size + 1) * hidden_size;
  endfunction

  function automatic int nn_n2(input int hidden_size, input int output_size);
    return (hidden_size + 1) * output_size;
  endfunction

  function automatic int nn_nw(input int input_size, input int hidden_size, input int output_size);
    return nn_n1(input_size, hidden_size) + nn_n2(hidden_size, output_size);
  endfunction

  // XOR network: w1 = {0,-1,1,1,1,1}, w2 = {0,1,-2}; words beyond those are zero.
  function automatic int nn_xor_default(input int idx, input int n1);
    if (idx < n1) begin
      case (idx)
        1:          return -1;
        2, 3, 4, 5: return 1;
        default:    return 0;
      endcase
    end else begin
      case (idx - n1)
        1:       return 1;
        2:       return -2;
        default: return 0;
      endcase
    end
  endfunction

endpackage

// File: rtl/nn_weight_bank.sv
// Shadow and active weight registers; the whole shadow set is copied to active on commit.
// Active words reset to the XOR network so the core always has a usable set.
module nn_weight_bank
  import nn_pkg::*;
#(
  parameter int WORD_W = BITS_PER_WORD_DEF,
  parameter int N1     = 6,
  parameter int NW     = 9,
  parameter int IDX_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [WORD_W-1:0]    wr_data,
  input  logic                 commit,
  output logic [NW*WORD_W-1:0] active_flat
);

  genvar gi;
  generate
    for (gi = 0; gi < NW; gi++) begin : g_word
      logic [WORD_W-1:0] shadow_reg;
      logic [WORD_W-1:0] active_reg;

      // Shadow needs no reset: its contents only matter once a full frame has landed.
      always_ff @(posedge clk) begin
        if (wr_en && (wr_idx == IDX_W'(gi))) begin
          shadow_reg <= wr_data;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          active_reg <= WORD_W'(nn_xor_default(gi, N1));
        end else if (commit) begin
          active_reg <= shadow_reg;
        end
      end

      assign active_flat[gi*WORD_W +: WORD_W] = active_reg;
    end
  endgenerate

endmodule

// File: rtl/nn_weight_loader.sv
// Streams one frame of weight words into shadow storage and commits it atomically to the core.
// NN_LOADER_CHECKSUM_EN adds a trailing mod-2^BITS checksum word that must match before commit.
module nn_weight_loader
  import nn_pkg::*;
#(
  parameter int BITS_PER_WORD = BITS_PER_WORD_DEF,
  parameter int INPUT_SIZE    = 2,
  parameter int HIDDEN_SIZE   = 2,
  parameter int OUTPUT_SIZE   = 1
) (
  input  logic                                                   clk,
  input  logic                                                   reset_n,
  input  logic                                                   s_valid,
  output logic                                                   s_ready,
  input  logic [BITS_PER_WORD-1:0]                               s_data,
  input  logic                                                   s_last,
  input  logic                                                   commit_hold,
  output logic [nn_n1(INPUT_SIZE, HIDDEN_SIZE)*BITS_PER_WORD-1:0] w1_flat,
  output logic [nn_n2(HIDDEN_SIZE, OUTPUT_SIZE)*BITS_PER_WORD-1:0] w2_flat,
  output logic                                                   load_done,
  output logic                                                   load_error
);

  localparam int N1 = nn_n1(INPUT_SIZE, HIDDEN_SIZE);
  localparam int NW = nn_nw(INPUT_SIZE, HIDDEN_SIZE, OUTPUT_SIZE);
`ifdef NN_LOADER_CHECKSUM_EN
  localparam int FRAME_LEN = NW + 1;
`else
  localparam int FRAME_LEN = NW;
`endif
  localparam int IDX_W = $clog2(FRAME_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] NW_IDX   = IDX_W'(NW);

  loader_state_t            state_reg, state_next;
  logic [IDX_W-1:0]         idx_reg, idx_next;
  logic                     load_done_reg, load_done_next;
  logic                     load_error_reg, load_error_next;
  logic                     accept, wr_en, commit, checksum_ok;
  logic [NW*BITS_PER_WORD-1:0] active_flat;

  assign s_ready    = (state_reg != COMMIT);
  assign accept     = s_valid & s_ready;
  assign wr_en      = accept && (state_reg == LOAD) && (idx_reg < NW_IDX);
  assign load_done  = load_done_reg;
  assign load_error = load_error_reg;

`ifdef NN_LOADER_CHECKSUM_EN
  logic [BITS_PER_WORD-1:0] sum_reg, sum_next;

  // Running sum restarts with word 0 so rejected frames never leak into the next one.
  always_comb begin
    sum_next = sum_reg;
    if (wr_en) begin
      sum_next = ((idx_reg == '0) ? '0 : sum_reg) + s_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_reg <= '0;
    end else begin
      sum_reg <= sum_next;
    end
  end

  assign checksum_ok = (s_data == sum_reg);
`else
  assign checksum_ok = 1'b1;
`endif

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    load_done_next  = 1'b0;
    load_error_next = 1'b0;
    commit          = 1'b0;
    case (state_reg)
      LOAD: begin
        if (accept) begin
          if (idx_reg == LAST_IDX) begin
            idx_next = '0;
            if (!s_last) begin
              state_next = DRAIN;
            end else if (checksum_ok) begin
              state_next = COMMIT;
            end else begin
              load_error_next = 1'b1;
            end
          end else if (s_last) begin
            idx_next        = '0;
            load_error_next = 1'b1;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (accept && s_last) begin
          state_next      = LOAD;
          idx_next        = '0;
          load_error_next = 1'b1;
        end
      end
      COMMIT: begin
        if (!commit_hold) begin
          commit         = 1'b1;
          load_done_next = 1'b1;
          state_next     = LOAD;
          idx_next       = '0;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= LOAD;
      idx_reg        <= '0;
      load_done_reg  <= 1'b0;
      load_error_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      load_done_reg  <= load_done_next;
      load_error_reg <= load_error_next;
    end
  end

  nn_weight_bank #(
    .WORD_W (BITS_PER_WORD),
    .N1     (N1),
    .NW     (NW),
    .IDX_W  (IDX_W)
  ) u_bank (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_idx      (idx_reg),
    .wr_data     (s_data),
    .commit      (commit),
    .active_flat (active_flat)
  );

  assign w1_flat = active_flat[N1*BITS_PER_WORD-1:0];
  assign w2_flat = active_flat[NW*BITS_PER_WORD-1:N1*BITS_PER_WORD];

endmodule

// File: tb/tb_nn_weight_loader.sv
// Self-checking bench for nn_weight_loader against a frame-level model of the active weight set.
// Define NN_LOADER_CHECKSUM_EN for both bench and RTL to exercise the checksummed frame format.
module tb_nn_weight_loader;

  localparam int B   = 8;
  localparam int IN  = 2;
  localparam int HID = 2;
  localparam int OUT = 1;
  localparam int N1  = (IN + 1) * HID;
  localparam int N2  = (HID + 1) * OUT;
  localparam int NW  = N1 + N2;
`ifdef NN_LOADER_CHECKSUM_EN
  localparam int FLEN = NW + 1;
`else
  localparam int FLEN = NW;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic            s_valid;
  logic            s_ready;
  logic [B-1:0]    s_data;
  logic            s_last;
  logic            commit_hold;
  logic [N1*B-1:0] w1_flat;
  logic [N2*B-1:0] w2_flat;
  logic            load_done;
  logic            load_error;
  logic [NW*B-1:0] dut_flat;

  int tests_run    = 0;
  int tests_failed = 0;
  int model[NW];
  int frame_q[$];

  nn_weight_loader #(
    .BITS_PER_WORD (B),
    .INPUT_SIZE    (IN),
    .HIDDEN_SIZE   (HID),
    .OUTPUT_SIZE   (OUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .commit_hold (commit_hold),
    .w1_flat     (w1_flat),
    .w2_flat     (w2_flat),
    .load_done   (load_done),
    .load_error  (load_error)
  );

  always #5 clk = ~clk;
  assign dut_flat = {w2_flat, w1_flat};

  function automatic void set_xor_model();
    int xw[NW] = '{0, -1, 1, 1, 1, 1, 0, 1, -2};
    for (int i = 0; i < NW; i++) model[i] = xw[i];
  endfunction

  function automatic logic [NW*B-1:0] model_flat();
    logic [NW*B-1:0] f;
    int v;
    for (int i = 0; i < NW; i++) begin
      v = model[i];
      f[i*B +: B] = v[B-1:0];
    end
    return f;
  endfunction

  // Frame of NW weights, plus the mod-2^B sum when the checksum format is enabled.
  function automatic void make_frame(input bit sequential, input int len_override);
    int sum = 0;
    int n;
    frame_q.delete();
    for (int i = 0; i < NW; i++) begin
      n = sequential ? i + 1 : int'($urandom_range(0, 255));
      frame_q.push_back(n);
      sum += n;
    end
`ifdef NN_LOADER_CHECKSUM_EN
    frame_q.push_back(sum % 256);
`endif
    while (len_override > 0 && frame_q.size() > len_override) void'(frame_q.pop_back());
    while (len_override > 0 && frame_q.size() < len_override) frame_q.push_back(int'($urandom_range(0, 255)));
  endfunction

  task automatic send_word(input logic [B-1:0] d, input logic l);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  task automatic send_frame(input int gaps_max);
    int v;
    for (int i = 0; i < frame_q.size(); i++) begin
      repeat ($urandom_range(0, gaps_max)) @(posedge clk);
      v = frame_q[i];
      send_word(v[B-1:0], i == frame_q.size() - 1);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; commit_hold = 1'b0;
    set_xor_model();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (dut_flat !== model_flat()) begin
      tests_failed++; $display("FAIL reset_weights: got %h expected %h", dut_flat, model_flat());
    end
    tests_run++;
    if (s_ready !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0) begin
      tests_failed++; $display("FAIL reset_flags: got ready=%b done=%b err=%b expected 1 0 0", s_ready, load_done, load_error);
    end
    @(negedge clk);
    reset_n = 1'b1;
    $display("[TB] reset: weights=%h", dut_flat);
  endtask

  // Full frame with hold low: commit on the edge after the final word, done for one cycle.
  task automatic test_frame(input int gaps_max, input bit sequential);
    make_frame(sequential, 0);
    send_frame(gaps_max);
    tests_run++;
    if (s_ready !== 1'b0 || load_done !== 1'b0 || dut_flat !== model_flat()) begin
      tests_failed++; $display("FAIL frame_pre_commit: got ready=%b done=%b w=%h expected 0 0 %h", s_ready, load_done, dut_flat, model_flat());
    end
    for (int i = 0; i < NW; i++) model[i] = frame_q[i];
    @(posedge clk);
    #1;
    tests_run++;
    if (dut_flat !== model_flat() || load_done !== 1'b1 || s_ready !== 1'b1) begin
      tests_failed++; $display("FAIL frame_commit: got w=%h done=%b ready=%b expected %h 1 1", dut_flat, load_done, s_ready, model_flat());
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (load_done !== 1'b0) begin
      tests_failed++; $display("FAIL frame_done_width: got done=%b expected 0", load_done);
    end
    $display("[TB] frame commit: weights=%h", dut_flat);
  endtask

  task automatic test_early_last();
    make_frame(1'b0, 4);
    send_frame(0);
    tests_run++;
    if (load_error !== 1'b1 || load_done !== 1'b0 || dut_flat !== model_flat()) begin
      tests_failed++; $display("FAIL early_error: got err=%b done=%b w=%h expected 1 0 %h", load_error, load_done, dut_flat, model_flat());
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (load_error !== 1'b0 || s_ready !== 1'b1 || dut_flat !== model_flat()) begin
      tests_failed++; $display("FAIL early_after: got err=%b ready=%b w=%h expected 0 1 %h", load_error, s_ready, dut_flat, model_flat());
    end
    $display("[TB] early s_last after 4 words: rejected");
    test_frame(0, 1'b0);
  endtask

  task automatic test_drain();
    int v;
    make_frame(1'b0, FLEN + 2);
    for (int i = 0; i < frame_q.size(); i++) begin
      tests_run++;
      if (s_ready !== 1'b1) begin
        tests_failed++; $display("FAIL drain_ready[%0d]: got %b expected 1", i, s_ready);
      end
      v = frame_q[i];
      send_word(v[B-1:0], i == frame_q.size() - 1);
      tests_run++;
      if (load_error !== (i == frame_q.size() - 1) || load_done !== 1'b0) begin
        tests_failed++; $display("FAIL drain_err[%0d]: got err=%b done=%b expected %b 0", i, load_error, load_done, i == frame_q.size() - 1);
      end
    end
    tests_run++;
    if (dut_flat !== model_flat()) begin
      tests_failed++; $display("FAIL drain_weights: got %h expected %h", dut_flat, model_flat());
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (load_error !== 1'b0) begin
      tests_failed++; $display("FAIL drain_err_width: got %b expected 0", load_error);
    end
    $display("[TB] overlong frame of %0d words: drained and rejected", frame_q.size());
    test_frame(1, 1'b0);
  endtask

  task automatic test_commit_hold();
    make_frame(1'b0, 0);
    commit_hold = 1'b1;
    send_frame(0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (s_ready !== 1'b0 || load_done !== 1'b0 || dut_flat !== model_flat()) begin
        tests_failed++; $display("FAIL hold_cycle%0d: got ready=%b done=%b w=%h expected 0 0 %h", c, s_ready, load_done, dut_flat, model_flat());
      end
    end
    commit_hold = 1'b0;
    for (int i = 0; i < NW; i++) model[i] = frame_q[i];
    @(posedge clk);
    #1;
    tests_run++;
    if (dut_flat !== model_flat() || load_done !== 1'b1 || s_ready !== 1'b1) begin
      tests_failed++; $display("FAIL hold_release: got w=%h done=%b ready=%b expected %h 1 1", dut_flat, load_done, s_ready, model_flat());
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (load_done !== 1'b0) begin
      tests_failed++; $display("FAIL hold_done_width: got %b expected 0", load_done);
    end
    $display("[TB] commit held 5 cycles: weights=%h", dut_flat);
  endtask

  task automatic test_reset_midframe();
    int v;
    make_frame(1'b0, 5);
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      v = frame_q[i];
      send_word(v[B-1:0], 1'b0);
    end
    @(negedge clk);
    reset_n = 1'b0;
    set_xor_model();
    #1;
    tests_run++;
    if (dut_flat !== model_flat() || s_ready !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0) begin
      tests_failed++; $display("FAIL midframe_reset: got w=%h ready=%b done=%b err=%b expected %h 1 0 0", dut_flat, s_ready, load_done, load_error, model_flat());
    end
    @(negedge clk);
    reset_n = 1'b1;
    $display("[TB] reset mid-frame: XOR set restored");
    test_frame(3, 1'b0);
  endtask

`ifdef NN_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    test_frame(0, 1'b1);
    make_frame(1'b1, 0);
    frame_q[NW] = 44;
    send_frame(0);
    tests_run++;
    if (load_error !== 1'b1 || s_ready !== 1'b1 || dut_flat !== model_flat()) begin
      tests_failed++; $display("FAIL checksum_bad: got err=%b ready=%b w=%h expected 1 1 %h", load_error, s_ready, dut_flat, model_flat());
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (load_done !== 1'b0 || dut_flat !== model_flat()) begin
      tests_failed++; $display("FAIL checksum_no_commit: got done=%b w=%h expected 0 %h", load_done, dut_flat, model_flat());
    end
    $display("[TB] checksum 44 on 1..9: rejected");
  endtask
`endif

  initial begin
    test_reset();
    test_frame(0, 1'b1);
    test_early_last();
    test_drain();
    test_commit_hold();
    test_frame(2, 1'b0);
    test_reset_midframe();
`ifdef NN_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
